// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundles the fetch-unit signals: the branch/jump redirect, the
//               instruction-memory request/grant/response handshake and the
//               valid/ready hand-off to decode.
//               master : the fetch unit (drives imem_req/addr, if_*, misalign_err)
//               slave  : the environment (memory, decode, branch resolution)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int SIZE = 32
) ();
    logic            redirect;
    logic [SIZE-1:0] redirect_pc;
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic [SIZE-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_ready;
    logic            misalign_err;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Instruction-fetch front end. Owns the PC, issues one word
//               fetch at a time over imem req/gnt/rvalid and hands each
//               instruction with its PC to decode over if_valid/if_ready.
//               Sequential PC is PC+4 (wraps modulo 2^SIZE); redirects load
//               redirect_pc in any state.
// Ports       : clk, rst (synchronous, active-high)
//               bus (pc_fetch_unit_if.master): redirect/redirect_pc,
//               imem_req/addr/gnt/rvalid/rdata, if_valid/pc/instr/ready,
//               misalign_err
// Option      : PC_ALIGN_CHECK_EN - reject redirects with redirect_pc[1:0]!=0
//               and pulse misalign_err; otherwise the low bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int              SIZE      = 32,
    parameter logic [SIZE-1:0] RESET_VEC = '0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pc_fetch_unit_if.master     bus
);

    localparam logic [SIZE-1:0] c_PC_STEP    = SIZE'(4);
    localparam logic [SIZE-1:0] c_ALIGN_MASK = SIZE'(3);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_pc;
    logic            r_drop;
    logic            r_req;
    logic            r_valid;
    logic [SIZE-1:0] r_if_pc;
    logic [31:0]     r_instr;
    logic            r_misalign;

    logic            w_redir_take;
    logic            w_redir_bad;
    logic [SIZE-1:0] w_redir_tgt;
    logic [SIZE-1:0] w_pc_inc;

`ifdef PC_ALIGN_CHECK_EN
    // A misaligned target is treated as if no redirect happened at all.
    assign w_redir_take = bus.redirect && ((bus.redirect_pc & c_ALIGN_MASK) == '0);
    assign w_redir_bad  = bus.redirect && ((bus.redirect_pc & c_ALIGN_MASK) != '0);
    assign w_redir_tgt  = bus.redirect_pc;
`else
    assign w_redir_take = bus.redirect;
    assign w_redir_bad  = 1'b0;
    assign w_redir_tgt  = bus.redirect_pc & ~c_ALIGN_MASK;
`endif

    // Carry out of the top bit is simply dropped.
    assign w_pc_inc = r_pc + c_PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_VEC;
            r_drop     <= 1'b0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_if_pc    <= RESET_VEC;
            r_instr    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redir_bad;
            case (r_state)
                S_FETCH: begin
                    if (w_redir_take) begin
                        r_pc <= w_redir_tgt;
                    end
                    if (!r_req) begin
                        // Only reached right after reset: raise the request;
                        // a grant cannot be taken while nothing is requested.
                        r_req <= 1'b1;
                    end else if (bus.imem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                        // Redirect together with grant: the fetch in flight
                        // is for the old PC, so its response must be dropped.
                        r_drop  <= w_redir_take;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_drop || w_redir_take) begin
                            r_drop  <= 1'b0;
                            r_req   <= 1'b1;
                            r_state <= S_FETCH;
                            if (w_redir_take) begin
                                r_pc <= w_redir_tgt;
                            end
                        end else begin
                            r_instr <= bus.imem_rdata;
                            r_if_pc <= r_pc;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end else if (w_redir_take) begin
                        r_pc   <= w_redir_tgt;
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect beats a simultaneous if_ready: the transfer
                    // is void and the PC does not advance.
                    if (w_redir_take) begin
                        r_pc    <= w_redir_tgt;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (bus.if_ready) begin
                        r_pc    <= w_pc_inc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

    // The fetch address is the PC register itself.
    assign bus.imem_req     = r_req;
    assign bus.imem_addr    = r_pc;
    assign bus.if_valid     = r_valid;
    assign bus.if_pc        = r_if_pc;
    assign bus.if_instr     = r_instr;
    assign bus.misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit. A behavioural memory
//               answers fetches with a randomized grant and response latency;
//               a transaction-level model tracks the PC that should be fetched
//               and delivered next (advance by 4 per accepted instruction,
//               jump to the aligned target on each effective redirect).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_RESET_VEC = 32'h0040_0000;

    logic clk;
    logic rst;

    pc_fetch_unit_if #(.SIZE(32)) bus ();

    pc_fetch_unit #(
        .SIZE      (32),
        .RESET_VEC (c_RESET_VEC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // memory / stimulus knobs
    int unsigned p_gnt   = 100;
    int unsigned p_ready = 100;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    bit          stale_once = 1'b0;

    // memory state
    bit          mem_pending = 1'b0;
    int unsigned mem_cnt     = 0;
    logic [31:0] mem_addr    = '0;
    logic [31:0] mem_data    = '0;

    // reference model
    logic [31:0] exp_pc   = c_RESET_VEC;
    int unsigned n_xfer   = 0;
    int unsigned cyc      = 0;
    bit          saw_stale = 1'b0;
    logic [31:0] fetch_addr_q[$];
    int unsigned fetch_cyc_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C00_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset_values();
        check("rst_req",      {31'b0, bus.imem_req},     32'd0);
        check("rst_addr",     bus.imem_addr,             c_RESET_VEC);
        check("rst_valid",    {31'b0, bus.if_valid},     32'd0);
        check("rst_if_pc",    bus.if_pc,                 c_RESET_VEC);
        check("rst_instr",    bus.if_instr,              32'd0);
        check("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
    endtask

    // One clock: drive memory/decode/redirect, update the model with the
    // event the DUT is about to see, clock, then check cycle invariants.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit          eff;
        bit          pmis;
        bit          pv, pr, preqgnt;
        logic [31:0] tgt, ppc, pinstr;

        bus.imem_rvalid = 1'b0;
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = stale_once ? 32'hDEAD_BEEF : mem_data;
                stale_once      = 1'b0;
                mem_pending     = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_gnt = bus.imem_req && !mem_pending && !bus.imem_rvalid
                       && ($urandom_range(99) < p_gnt);
        bus.if_ready    = ($urandom_range(99) < p_ready);
        bus.redirect    = redir;
        bus.redirect_pc = rpc;

`ifdef PC_ALIGN_CHECK_EN
        eff  = redir && (rpc[1:0] == 2'b00);
        pmis = redir && (rpc[1:0] != 2'b00);
        tgt  = rpc;
`else
        eff  = redir;
        pmis = 1'b0;
        tgt  = {rpc[31:2], 2'b00};
`endif

        if (bus.imem_req && bus.imem_gnt) begin
            check("gnt_addr", bus.imem_addr, exp_pc);
            mem_pending = 1'b1;
            mem_cnt     = $urandom_range(lat_max, lat_min);
            mem_addr    = bus.imem_addr;
            mem_data    = mem_fn(bus.imem_addr);
            fetch_addr_q.push_back(bus.imem_addr);
            fetch_cyc_q.push_back(cyc);
        end
        if (bus.if_valid && bus.if_ready && !eff) begin
            check("xfer_pc",    bus.if_pc,    exp_pc);
            check("xfer_instr", bus.if_instr, mem_fn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (eff) exp_pc = tgt;

        pv      = bus.if_valid;
        pr      = bus.if_ready;
        ppc     = bus.if_pc;
        pinstr  = bus.if_instr;
        preqgnt = bus.imem_req && bus.imem_gnt;

        @(posedge clk);
        #1;
        cyc++;

        check("misalign", {31'b0, bus.misalign_err}, {31'b0, pmis});
        if (preqgnt) check("req_drop_after_gnt", {31'b0, bus.imem_req}, 32'd0);
        check("one_outstanding", {31'b0, bus.imem_req && mem_pending}, 32'd0);
        if (pv && !pr && !eff) begin
            check("hold_valid", {31'b0, bus.if_valid}, 32'd1);
            check("hold_pc",    bus.if_pc,    ppc);
            check("hold_instr", bus.if_instr, pinstr);
        end
        if (bus.if_valid && bus.if_instr == 32'hDEAD_BEEF) saw_stale = 1'b1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.if_ready    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_values();
        rst         = 1'b0;
        mem_pending = 1'b0;
        stale_once  = 1'b0;
        exp_pc      = c_RESET_VEC;
    endtask

    // Tick without redirect until imem_req (sel=0) or if_valid (sel=1).
    task automatic wait_for(input int sel, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((sel == 0 && bus.imem_req) || (sel == 1 && bus.if_valid)) begin
                ok = 1'b1;
                break;
            end
            tick(1'b0, '0);
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] cur;
        bit          found;

        rst = 1'b1;
        do_reset();

        // --- best-case streaming from RESET_VEC ---
        p_gnt = 100; p_ready = 100; lat_min = 0; lat_max = 0;
        fetch_addr_q.delete();
        fetch_cyc_q.delete();
        tick(1'b0, '0);
        check("first_req",  {31'b0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, c_RESET_VEC);
        for (int i = 0; i < 8; i++) tick(1'b0, '0);
        check("stream_cnt", fetch_addr_q.size(), 32'd3);
        if (fetch_addr_q.size() >= 3) begin
            check("stream_a0", fetch_addr_q[0], c_RESET_VEC);
            check("stream_a1", fetch_addr_q[1], c_RESET_VEC + 32'd4);
            check("stream_a2", fetch_addr_q[2], c_RESET_VEC + 32'd8);
            check("stream_gap1", fetch_cyc_q[1] - fetch_cyc_q[0], 32'd3);
            check("stream_gap2", fetch_cyc_q[2] - fetch_cyc_q[1], 32'd3);
        end

        // --- decode stalls for 5 cycles in HOLD ---
        p_ready = 0;
        wait_for(1, "reach_hold");
        held_pc = bus.if_pc;
        check("hold_pc_val", held_pc, c_RESET_VEC + 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0);
            check("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
            check("stall_addr",   bus.imem_addr, held_pc);
        end
        p_ready = 100;
        tick(1'b0, '0);
        check("release_valid", {31'b0, bus.if_valid}, 32'd0);
        check("release_req",   {31'b0, bus.imem_req}, 32'd1);
        check("release_addr",  bus.imem_addr, held_pc + 32'd4);

        // --- redirect while waiting for a response ---
        lat_min = 2; lat_max = 2;
        tick(1'b0, '0);
        check("in_wait", {31'b0, bus.imem_req}, 32'd0);
        stale_once = 1'b1;
        saw_stale  = 1'b0;
        tick(1'b1, 32'h0000_1000);
        wait_for(0, "refetch_req");
        check("refetch_addr", bus.imem_addr, 32'h0000_1000);
        for (int i = 0; i < 8; i++) tick(1'b0, '0);
        check("no_stale", {31'b0, saw_stale}, 32'd0);

        // --- redirect and if_ready in the same HOLD cycle ---
        lat_min = 0; lat_max = 0; p_ready = 0;
        wait_for(1, "reach_hold2");
        p_ready = 100;
        tick(1'b1, 32'h0000_2000);
        check("rh_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rh_req",   {31'b0, bus.imem_req}, 32'd1);
        check("rh_addr",  bus.imem_addr, 32'h0000_2000);

        // --- PC wrap ---
        tick(1'b1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.imem_req && bus.imem_addr == 32'h0) begin
                found = 1'b1;
                break;
            end
            tick(1'b0, '0);
        end
        check("wrap_to_zero", {31'b0, found}, 32'd1);

        // --- misaligned redirect while a request is pending ---
        p_gnt = 0;
        wait_for(0, "mis_req");
        cur = bus.imem_addr;
        tick(1'b1, 32'h0000_1002);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pulse", {31'b0, bus.misalign_err}, 32'd1);
        check("mis_addr",  bus.imem_addr, cur);
`else
        check("mis_pulse", {31'b0, bus.misalign_err}, 32'd0);
        check("mis_addr",  bus.imem_addr, 32'h0000_1000);
`endif
        tick(1'b0, '0);
        check("mis_once", {31'b0, bus.misalign_err}, 32'd0);
        p_gnt = 100;

        // --- reset in the middle of WAIT, then a late response ---
        lat_min = 3; lat_max = 3;
        wait_for(0, "rw_req");
        tick(1'b0, '0);
        check("rw_in_wait", {31'b0, bus.imem_req}, 32'd0);
        rst             = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        @(posedge clk); #1;
        check_reset_values();
        rst             = 1'b0;
        mem_pending     = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_rvalid = 1'b0;
        exp_pc = c_RESET_VEC;
        check("late_rv_valid", {31'b0, bus.if_valid}, 32'd0);
        check("late_rv_req",   {31'b0, bus.imem_req}, 32'd1);
        check("late_rv_addr",  bus.imem_addr, c_RESET_VEC);
        lat_min = 0; lat_max = 0;
        saw_stale = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0, '0);
        check("late_rv_ignored", {31'b0, saw_stale}, 32'd0);

        // --- randomized traffic against the model ---
        n_xfer = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if (i % 200 == 0) begin
                p_gnt   = $urandom_range(100, 30);
                p_ready = $urandom_range(100, 20);
                lat_min = 0;
                lat_max = $urandom_range(3, 0);
            end
            rpc = $urandom;
            if ($urandom_range(9) < 7) rpc[1:0] = 2'b00;
            if ($urandom_range(19) == 0) rpc = 32'hFFFF_FFFC;
            tick($urandom_range(99) < 6, rpc);
        end
        check("random_progress", {31'b0, n_xfer > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Instruction-fetch front end of the MIPS_32 pipeline.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Presents each fetched instruction with its PC to the decode stage over a valid/ready interface.
- Computes the sequential next PC as PC + 4 and accepts branch/jump redirects.

## Interface
- SIZE, 32: width of PC and address.
- RESET_VEC, 0: PC of the first fetch after reset.

- clk  input  1  clock; everything on the rising edge.
- rst  input  1  synchronous reset, active-high.
- redirect  input  1  branch/jump taken this cycle.
- redirect_pc  input  SIZE  target PC when redirect=1.
- imem_req  output  1  fetch request.
- imem_addr  output  SIZE  fetch address, held stable while imem_req=1.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  fetched instruction.
- if_valid  output  1  instruction available to decode.
- if_pc  output  SIZE  PC of if_instr.
- if_instr  output  32  instruction word.
- if_ready  input  1  decode accepts the instruction.
- misalign_err  output  1  one-cycle pulse on a rejected redirect (only with the macro; tied 0 otherwise).

## Operation
- Registers: pc, FSM state, drop flag. All outputs are registered.
- One request may be outstanding at a time.
- **FETCH**
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: go to WAIT.
- **WAIT**
  - imem_req=0.
  - On imem_rvalid with drop=0: capture if_instr=imem_rdata and if_pc=pc, set if_valid=1, go to HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, go to FETCH.
- **HOLD**
  - if_valid=1.
  - On if_ready: pc <= pc+4, if_valid <= 0, go to FETCH.
- **Redirect handling** (pc <= redirect_pc in every case)
  - In FETCH before grant: imem_addr changes to the target next cycle. A redirect in the same cycle as imem_gnt acts as the WAIT case.
  - In WAIT: set drop. The stale response is discarded, then FETCH the target.
  - Redirect in the same cycle as imem_rvalid: the response is discarded, and FETCH of the target starts next cycle.
  - In HOLD: if_valid <= 0, go to FETCH. If if_ready is also 1 that cycle, the transfer is void; redirect wins and pc does not advance.
- **Arithmetic**: pc+4 is modulo 2^SIZE, so 0xFFFFFFFC wraps to 0x00000000. No carry out.
- **Reset**
  - rst overrides everything, including mid-request.
  - State <= FETCH-pending, pc <= RESET_VEC, drop <= 0.
  - Any response arriving after reset with no request issued is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_VEC, if_valid=0, if_pc=RESET_VEC, if_instr=0, misalign_err=0.
- Cycle 1 after rst falls: imem_req=1, imem_addr=RESET_VEC.
- Latency: if_valid rises one cycle after the imem_rvalid edge.
- Best-case throughput: one instruction per 3 cycles (grant, rvalid, ready each in consecutive cycles).
- imem_req is deasserted the cycle after imem_gnt.
- imem_addr never changes while imem_req=1 except on redirect.
- if_pc and if_instr are stable while if_valid=1 and if_ready=0.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect_pc with bits [1:0] != 0 is ignored; state and pc are unchanged.
  - misalign_err pulses 1 for one cycle, one cycle after the redirect.
- PC_ALIGN_CHECK_EN undefined:
  - redirect_pc[1:0] is forced to 0 when loaded.
  - misalign_err is constant 0.

## Test plan
- Reset, RESET_VEC=0x00400000, memory with gnt same-cycle and rvalid next cycle, if_ready=1 -> fetch addresses 0x00400000, 0x00400004, 0x00400008; if_pc matches each address; one instruction per 3 cycles.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stable; no imem_req; PC advances by 4 only after if_ready=1.
- Redirect to 0x00001000 while in WAIT -> stale rdata 0xDEADBEEF is never presented; next imem_addr=0x00001000.
- Redirect plus if_ready in the same HOLD cycle -> if_valid drops; next fetch is redirect_pc, not pc+4.
- pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000.
- Redirect to 0x00001002:
  - With PC_ALIGN_CHECK_EN -> misalign_err pulses once and the next fetch is sequential.
  - Without it -> the next fetch is 0x00001000.
- rst asserted mid-WAIT -> all outputs take their reset values the next cycle; a late rvalid is ignored; the fetch restarts at RESET_VEC.
